// File: rtl/flyhigh_pkg.sv
// Shared types for the flyhigh collision/score block: game states, packed BCD score
// and the saturation ceiling.
package flyhigh_pkg;

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_RESPAWN   = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_t;

  typedef logic [15:0] bcd4_t;

  localparam bcd4_t SCORE_MAX = 16'h9999;

  // Packed BCD orders the same way as plain binary, so a binary compare suffices
  function automatic bcd4_t bcd4_max(input bcd4_t a, input bcd4_t b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/bcd_add4.sv
// Combinational saturating add of a single 0..9 digit into a 4-digit packed BCD value.
module bcd_add4 import flyhigh_pkg::*; (
  input  bcd4_t      augend,
  input  logic [3:0] addend,
  output bcd4_t      sum
);

  logic [4:0] dsum_s;
  logic [4:0] add_s;
  logic       carry_s;
  bcd4_t      raw_s;

  // Ripple the decimal carry digit by digit; a carry out of the top digit means overflow
  always_comb begin
    raw_s   = 16'h0000;
    carry_s = 1'b0;
    dsum_s  = 5'd0;
    add_s   = 5'd0;
    for (int i = 0; i < 4; i++) begin
      add_s  = (i == 0) ? {1'b0, addend} : 5'd0;
      dsum_s = {1'b0, augend[4*i +: 4]} + add_s + {4'd0, carry_s};
      if (dsum_s > 5'd9) begin
        dsum_s  = dsum_s - 5'd10;
        carry_s = 1'b1;
      end else begin
        carry_s = 1'b0;
      end
      raw_s[4*i +: 4] = dsum_s[3:0];
    end
  end

  assign sum = carry_s ? SCORE_MAX : raw_s;

endmodule

// File: rtl/collision_score.sv
// Frame-based collision scoring: hit/crash latching, lives, respawn invulnerability and score.
// Optional high-score register enabled by FLYHIGH_HISCORE_EN.
module collision_score import flyhigh_pkg::*; #(
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int HIT_POINTS    = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pix_stb,
  input  logic        i_animate,
  input  logic        i_paused,
  input  logic        i_ship,
  input  logic        i_bullet,
  input  logic        i_enemy,
  input  logic        i_start,
  output logic [15:0] o_score,
  output logic [15:0] o_hiscore,
  output logic [1:0]  o_lives,
  output logic        o_hit,
  output logic        o_crash,
  output logic        o_game_over,
  output logic        o_flash
);

  localparam logic [1:0] LIVES_INIT  = 2'(START_LIVES);
  localparam logic [7:0] INVULN_INIT = 8'(INVULN_FRAMES);
  localparam logic [3:0] HIT_ADD     = 4'(HIT_POINTS);

  state_t     state_r, state_nxt_s;
  bcd4_t      score_r, score_nxt_s, sum_s;
  logic [1:0] lives_r, lives_nxt_s;
  logic [7:0] cnt_r, cnt_nxt_s;
  logic       hit_lat_r, crash_lat_r;
  logic       hit_r, hit_nxt_s, crash_r, crash_nxt_s;
  logic       flash_r, game_over_r;
  logic       frame_end_s, act_s;

  assign frame_end_s = i_pix_stb & i_animate;
  assign act_s       = frame_end_s & ~i_paused;

  bcd_add4 u_bcd_add4 (
    .augend (score_r),
    .addend (HIT_ADD),
    .sum    (sum_s)
  );

  // Overlap latches: accumulate over the frame, cleared at every frame-end even when paused
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hit_lat_r   <= 1'b0;
      crash_lat_r <= 1'b0;
    end else if (frame_end_s) begin
      hit_lat_r   <= 1'b0;
      crash_lat_r <= 1'b0;
    end else if (i_pix_stb) begin
      hit_lat_r   <= hit_lat_r | (i_bullet & i_enemy);
      crash_lat_r <= crash_lat_r | (i_ship & i_enemy);
    end else begin
      hit_lat_r   <= hit_lat_r;
      crash_lat_r <= crash_lat_r;
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= ST_PLAY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; nothing moves except at an unpaused frame-end
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_PLAY: begin
        if (act_s && crash_lat_r) begin
          state_nxt_s = (lives_r > 2'd1) ? ST_RESPAWN : ST_GAME_OVER;
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      ST_RESPAWN: begin
        if (act_s && (cnt_r <= 8'd1)) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_RESPAWN;
        end
      end
      ST_GAME_OVER: begin
        if (act_s && i_start) begin
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_GAME_OVER;
        end
      end
      default: state_nxt_s = ST_PLAY;
    endcase
  end

  // Next values of score, lives, invulnerability counter and event pulses
  always_comb begin
    score_nxt_s = score_r;
    lives_nxt_s = lives_r;
    cnt_nxt_s   = cnt_r;
    hit_nxt_s   = 1'b0;
    crash_nxt_s = 1'b0;
    case (state_r)
      ST_PLAY: begin
        if (act_s) begin
          if (hit_lat_r) begin
            score_nxt_s = sum_s;
            hit_nxt_s   = 1'b1;
          end else begin
            hit_nxt_s   = 1'b0;
          end
          if (crash_lat_r) begin
            crash_nxt_s = 1'b1;
            if (lives_r > 2'd1) begin
              lives_nxt_s = lives_r - 2'd1;
              cnt_nxt_s   = INVULN_INIT;
            end else begin
              lives_nxt_s = 2'd0;
            end
          end else begin
            crash_nxt_s = 1'b0;
          end
        end else begin
          hit_nxt_s = 1'b0;
        end
      end
      ST_RESPAWN: begin
        if (act_s) begin
          if (hit_lat_r) begin
            score_nxt_s = sum_s;
            hit_nxt_s   = 1'b1;
          end else begin
            hit_nxt_s   = 1'b0;
          end
          cnt_nxt_s = (cnt_r == 8'd0) ? 8'd0 : cnt_r - 8'd1;
        end else begin
          hit_nxt_s = 1'b0;
        end
      end
      ST_GAME_OVER: begin
        if (act_s && i_start) begin
          score_nxt_s = 16'h0000;
          lives_nxt_s = LIVES_INIT;
        end else begin
          score_nxt_s = score_r;
        end
      end
      default: begin
        score_nxt_s = score_r;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      score_r     <= 16'h0000;
      lives_r     <= LIVES_INIT;
      cnt_r       <= 8'd0;
      hit_r       <= 1'b0;
      crash_r     <= 1'b0;
      flash_r     <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      score_r     <= score_nxt_s;
      lives_r     <= lives_nxt_s;
      cnt_r       <= cnt_nxt_s;
      hit_r       <= hit_nxt_s;
      crash_r     <= crash_nxt_s;
      flash_r     <= (state_nxt_s == ST_RESPAWN) & cnt_nxt_s[2];
      game_over_r <= (state_nxt_s == ST_GAME_OVER);
    end
  end

`ifdef FLYHIGH_HISCORE_EN
  bcd4_t hiscore_r;

  // Best score is captured on entry to GAME_OVER and survives restarts
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hiscore_r <= 16'h0000;
    end else if ((state_r != ST_GAME_OVER) && (state_nxt_s == ST_GAME_OVER)) begin
      hiscore_r <= bcd4_max(hiscore_r, score_nxt_s);
    end else begin
      hiscore_r <= hiscore_r;
    end
  end

  assign o_hiscore = hiscore_r;
`else
  assign o_hiscore = 16'h0000;
`endif

  assign o_score     = score_r;
  assign o_lives     = lives_r;
  assign o_hit       = hit_r;
  assign o_crash     = crash_r;
  assign o_flash     = flash_r;
  assign o_game_over = game_over_r;

endmodule

// File: tb/tb_collision_score.sv
// Directed bench for collision_score with default parameters; hiscore expectation
// follows FLYHIGH_HISCORE_EN.
module tb_collision_score;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_pix_stb, i_animate, i_paused;
  logic        i_ship, i_bullet, i_enemy, i_start;
  logic [15:0] o_score, o_hiscore;
  logic [1:0]  o_lives;
  logic        o_hit, o_crash, o_game_over, o_flash;

  int checks = 0;
  int errors = 0;

`ifdef FLYHIGH_HISCORE_EN
  localparam logic [15:0] HI_GO = 16'h0102;
`else
  localparam logic [15:0] HI_GO = 16'h0000;
`endif

  collision_score dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_pix_stb   (i_pix_stb),
    .i_animate   (i_animate),
    .i_paused    (i_paused),
    .i_ship      (i_ship),
    .i_bullet    (i_bullet),
    .i_enemy     (i_enemy),
    .i_start     (i_start),
    .o_score     (o_score),
    .o_hiscore   (o_hiscore),
    .o_lives     (o_lives),
    .o_hit       (o_hit),
    .o_crash     (o_crash),
    .o_game_over (o_game_over),
    .o_flash     (o_flash)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic b, input logic s, input logic e);
    i_pix_stb = 1'b1; i_bullet = b; i_ship = s; i_enemy = e;
    tick();
    i_pix_stb = 1'b0; i_bullet = 1'b0; i_ship = 1'b0; i_enemy = 1'b0;
  endtask

  task automatic fend();
    i_pix_stb = 1'b1; i_animate = 1'b1;
    tick();
    i_pix_stb = 1'b0; i_animate = 1'b0;
  endtask

  task automatic hits(input int n);
    for (int k = 0; k < n; k++) begin
      pix(1'b1, 1'b0, 1'b1);
      fend();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_score"}, {16'd0, o_score}, 32'h0000);
    chk({tag, "_hiscore"}, {16'd0, o_hiscore}, 32'h0000);
    chk({tag, "_lives"}, {30'd0, o_lives}, 32'd3);
    chk({tag, "_flags"}, {28'd0, o_hit, o_crash, o_flash, o_game_over}, 32'd0);
  endtask

  int crash_cnt;

  initial begin
    i_rst_n = 1'b0; i_pix_stb = 1'b0; i_animate = 1'b0; i_paused = 1'b0;
    i_ship = 1'b0; i_bullet = 1'b0; i_enemy = 1'b0; i_start = 1'b0;
    tick(); tick();
    i_rst_n = 1'b1;
    chk_reset("rst");

    // five overlapping pixels -> one hit
    for (int k = 0; k < 5; k++) pix(1'b1, 1'b0, 1'b1);
    fend();
    chk("hit5_pulse", {31'd0, o_hit}, 32'd1);
    chk("hit5_crash", {31'd0, o_crash}, 32'd0);
    chk("hit5_score", {16'd0, o_score}, 32'h0001);
    tick();
    chk("hit_width", {31'd0, o_hit}, 32'd0);

    // paused frame-end changes nothing, next unpaused frame sees clean latches
    i_paused = 1'b1;
    pix(1'b1, 1'b1, 1'b1);
    fend();
    chk("pause_score", {16'd0, o_score}, 32'h0001);
    chk("pause_lives", {30'd0, o_lives}, 32'd3);
    chk("pause_pulses", {30'd0, o_hit, o_crash}, 32'd0);
    i_paused = 1'b0;
    fend();
    chk("unpause_score", {16'd0, o_score}, 32'h0001);
    chk("unpause_lives", {30'd0, o_lives}, 32'd3);
    chk("unpause_pulses", {30'd0, o_hit, o_crash}, 32'd0);

    hits(98);
    chk("score_0099", {16'd0, o_score}, 32'h0099);
    hits(1);
    chk("score_0100", {16'd0, o_score}, 32'h0100);

    // crash at 3 lives -> respawn with 60 frames of invulnerability
    pix(1'b0, 1'b1, 1'b1);
    fend();
    chk("crash1_pulse", {30'd0, o_hit, o_crash}, 32'd1);
    chk("crash1_lives", {30'd0, o_lives}, 32'd2);
    chk("crash1_flash", {31'd0, o_flash}, 32'd1);
    pix(1'b1, 1'b1, 1'b1);
    fend();
    chk("resp_hit", {30'd0, o_hit, o_crash}, 32'd2);
    chk("resp_score", {16'd0, o_score}, 32'h0101);
    chk("resp_flash1", {31'd0, o_flash}, 32'd0);
    crash_cnt = 0;
    for (int k = 2; k <= 60; k++) begin
      pix(1'b0, 1'b1, 1'b1);
      fend();
      crash_cnt += int'(o_crash);
      if (k == 5) chk("resp_flash5", {31'd0, o_flash}, 32'd1);
    end
    chk("resp_no_crash", crash_cnt, 32'd0);
    chk("resp_lives", {30'd0, o_lives}, 32'd2);
    chk("resp_end_flash", {31'd0, o_flash}, 32'd0);
    pix(1'b0, 1'b1, 1'b1);
    fend();
    chk("crash2_pulse", {31'd0, o_crash}, 32'd1);
    chk("crash2_lives", {30'd0, o_lives}, 32'd1);
    for (int k = 0; k < 60; k++) fend();

    // hit and crash together on the last life
    pix(1'b1, 1'b1, 1'b1);
    fend();
    chk("last_pulses", {30'd0, o_hit, o_crash}, 32'd3);
    chk("last_score", {16'd0, o_score}, 32'h0102);
    chk("last_lives", {30'd0, o_lives}, 32'd0);
    chk("last_go", {31'd0, o_game_over}, 32'd1);
    chk("last_hiscore", {16'd0, o_hiscore}, {16'd0, HI_GO});

    pix(1'b1, 1'b1, 1'b1);
    fend();
    chk("go_ignore_pulses", {30'd0, o_hit, o_crash}, 32'd0);
    chk("go_ignore_score", {16'd0, o_score}, 32'h0102);
    chk("go_hold", {31'd0, o_game_over}, 32'd1);

    i_start = 1'b1;
    fend();
    i_start = 1'b0;
    chk("restart_score", {16'd0, o_score}, 32'h0000);
    chk("restart_lives", {30'd0, o_lives}, 32'd3);
    chk("restart_go", {31'd0, o_game_over}, 32'd0);
    chk("restart_hiscore", {16'd0, o_hiscore}, {16'd0, HI_GO});

    // decimal carries and saturation
    hits(999);
    chk("score_0999", {16'd0, o_score}, 32'h0999);
    hits(1);
    chk("score_1000", {16'd0, o_score}, 32'h1000);
    hits(8999);
    chk("score_9999", {16'd0, o_score}, 32'h9999);
    hits(1);
    chk("sat_hit", {31'd0, o_hit}, 32'd1);
    chk("sat_score", {16'd0, o_score}, 32'h9999);

    // reset mid-frame discards a latched hit
    pix(1'b1, 1'b0, 1'b1);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    chk_reset("rst2");
    fend();
    chk("post_rst_hit", {31'd0, o_hit}, 32'd0);
    chk("post_rst_score", {16'd0, o_score}, 32'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
